// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM encoding,
// memory depth and burst-counter sizing.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam int DMEM_DEPTH     = 1024;
  localparam int DMEM_MAX_BURST = 4;
  localparam int BURST_CNT_W    = $clog2(DMEM_MAX_BURST + 1);

  // Counter must be able to hold the value max_burst itself (it saturates there).
  function automatic int burst_cnt_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin selector: a lone request wins outright, a tie goes to
// the requester that did not win last.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter with bounded burst lock sharing one single-port data
// memory between a core port (m0) and a loader/debug port (m1).
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int N         = 32,
  parameter int DEPTH     = DMEM_DEPTH,
  parameter int MAX_BURST = DMEM_MAX_BURST
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         m0_req,
  input  logic         m0_we,
  input  logic         m0_lock,
  input  logic [N-1:0] m0_addr,
  input  logic [N-1:0] m0_wdata,
  output logic         m0_gnt,
  output logic         m0_rvalid,
  output logic         m0_err,
  output logic [N-1:0] m0_rdata,
  input  logic         m1_req,
  input  logic         m1_we,
  input  logic         m1_lock,
  input  logic [N-1:0] m1_addr,
  input  logic [N-1:0] m1_wdata,
  output logic         m1_gnt,
  output logic         m1_rvalid,
  output logic         m1_err,
  output logic [N-1:0] m1_rdata,
  output logic         mem_WE,
  output logic [N-1:0] mem_A,
  output logic [N-1:0] mem_WD,
  input  logic [N-1:0] mem_RD
);

  localparam int CW = burst_cnt_w(MAX_BURST);

  logic [1:0]   req;
  logic [1:0]   we;
  logic [1:0]   lock;
  logic [N-1:0] addr  [2];
  logic [N-1:0] wdata [2];
  logic [1:0]   in_range;

  assign req      = {m1_req, m0_req};
  assign we       = {m1_we, m0_we};
  assign lock     = {m1_lock, m0_lock};
  assign addr[0]  = m0_addr;
  assign addr[1]  = m1_addr;
  assign wdata[0] = m0_wdata;
  assign wdata[1] = m1_wdata;

  for (genvar gi = 0; gi < 2; gi++) begin : g_range
    assign in_range[gi] = (addr[gi] < N'(DEPTH));
  end

  arb_state_t    state_reg, state_next;
  logic          last_reg, last_next;
  logic [CW-1:0] cnt_reg, cnt_next;

  logic       rr_last;
  logic [1:0] pick_gnt;
  logic [1:0] gnt_sel;
  logic [1:0] gnt;
  logic       owner;
  logic       keep;
  logic       win;

  // While a burst owner exists, the other side gets tie priority when it ends.
  assign rr_last = (state_reg == OWN0) ? 1'b0 :
                   (state_reg == OWN1) ? 1'b1 : last_reg;

  rr_pick2 u_pick (
    .req  (req),
    .last (rr_last),
    .gnt  (pick_gnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      last_reg  <= 1'b1;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    owner      = (state_reg == OWN1);
    keep       = 1'b0;
    state_next = IDLE;
    cnt_next   = '0;
    last_next  = last_reg;
    if (state_reg != IDLE) begin
      keep = req[owner] &&
             (!lock[owner] || (cnt_reg < CW'(MAX_BURST)) || !req[~owner]);
    end
    gnt_sel = keep ? (owner ? 2'b10 : 2'b01) : pick_gnt;
    win     = gnt_sel[1];
    if (|gnt_sel) begin
      last_next = win;
      if (lock[win]) begin
        state_next = win ? OWN1 : OWN0;
        if (!keep) begin
          cnt_next = CW'(1);
        end else if (cnt_reg == CW'(MAX_BURST)) begin
          cnt_next = cnt_reg;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
    end
  end

  // Grants are masked during reset so the memory is never driven while held.
  always_comb begin
    gnt    = gnt_sel & {2{rst}};
    mem_WE = 1'b0;
    mem_A  = '0;
    mem_WD = '0;
    if (|gnt) begin
      mem_A  = addr[win];
      mem_WD = wdata[win];
      mem_WE = we[win] & in_range[win];
    end
  end

  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];

  logic [1:0]        rvalid_reg;
  logic [1:0]        err_reg;
  logic [1:0][N-1:0] rdata_reg;

  // In-range writes are silent; reads and any out-of-range access respond next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid_reg <= '0;
      err_reg    <= '0;
      rdata_reg  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (gnt[i] && (!we[i] || !in_range[i])) begin
          rvalid_reg[i] <= 1'b1;
          err_reg[i]    <= !in_range[i];
          rdata_reg[i]  <= in_range[i] ? mem_RD : '0;
        end else begin
          rvalid_reg[i] <= 1'b0;
          err_reg[i]    <= 1'b0;
          rdata_reg[i]  <= '0;
        end
      end
    end
  end

  assign m0_rvalid = rvalid_reg[0];
  assign m0_err    = err_reg[0];
  assign m0_rdata  = rdata_reg[0];
  assign m1_rvalid = rvalid_reg[1];
  assign m1_err    = err_reg[1];
  assign m1_rdata  = rdata_reg[1];

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter sharing the single-port data memory (N-bit words, 1024 entries, combinational read, posedge write) between requester 0 (core load/store) and requester 1 (loader/debug DMA).
- Grants one access per cycle using round-robin with an optional bounded lock for back-to-back bursts.
- Returns registered read data with a valid strobe one cycle after grant, and flags out-of-range addresses.
- Sits between the requesters and the memory; it is the only driver of the memory's WE/A/WD.

Parameters:
- N, 32, data and address width.
- DEPTH, 1024, number of memory words; the legal word address range is 0..DEPTH-1.
- MAX_BURST, 4, maximum consecutive locked grants before a forced hand-over when the other requester is waiting.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-low
- m0_req  input  1  requester 0 access request, held until granted
- m0_we  input  1  requester 0 write (1) / read (0)
- m0_lock  input  1  requester 0 asks to keep ownership after this access
- m0_addr  input  N  requester 0 word address
- m0_wdata  input  N  requester 0 write data
- m0_gnt  output  1  requester 0 access accepted this cycle
- m0_rvalid  output  1  requester 0 response valid (reads and errors)
- m0_err  output  1  requester 0 out-of-range access, qualified by m0_rvalid
- m0_rdata  output  N  requester 0 read data, qualified by m0_rvalid
- m1_*  same set as m0_* for requester 1
- mem_WE  output  1  memory write enable
- mem_A  output  N  memory address
- mem_WD  output  N  memory write data
- mem_RD  input  N  memory read data (combinational)

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, last=1 (requester 0 wins the first tie), burst count=0.
  - All gnt, rvalid, err = 0; rdata = 0.
  - Any response pending at reset is dropped.
- Grant is combinational from state and requests. At most one gnt is high per cycle. A request is accepted on the rising edge where req and gnt are both 1.
- Memory drive in the grant cycle:
  - mem_A = winner addr; mem_WD = winner wdata.
  - mem_WE = winner we AND addr < DEPTH.
  - With no grant: mem_WE = 0, mem_A = 0, mem_WD = 0.
- Read: mem_RD is captured at the grant edge. The winner's rvalid=1, rdata=captured value, err=0 for exactly the next cycle.
- Write: the memory updates at the grant edge. No rvalid is generated for an in-range write.
- Out-of-range access (addr >= DEPTH):
  - The access is granted, but there is no memory write and the memory read is ignored.
  - Next cycle: rvalid=1, err=1, rdata=0. This applies to reads and writes.
- The rvalid/err/rdata of the non-responding requester stay 0. rdata returns to 0 when rvalid falls.
- FSM states: IDLE, OWN0, OWN1.
  - IDLE: a single request is granted to its requester. If both request, grant goes to the requester != last. last is updated to the winner.
    - If the winner has lock=1: go to OWNx with count=1.
  - OWNx, requester x requests with lock=1 and (count < MAX_BURST or the other requester is idle): grant x, count+1 saturating at MAX_BURST, stay in OWNx.
  - OWNx, requester x requests with lock=0: grant x, return to IDLE.
  - OWNx, x idle, or count = MAX_BURST with the other requesting: no grant to x; return to IDLE this cycle.
    - The other requester is granted in the same cycle through the IDLE rules with last=x, giving it priority.
    - If the other requester holds lock=1, go to its OWN state with count=1.
- Back-to-back: a new grant is allowed every cycle. Response pipelines for the two requesters are independent.
- Simultaneous write and read to the same address by the two requesters: they are serialized by the arbiter. The loser sees the winner's write if granted later.

Decomposition:
- Shared package dmem_pkg:
  - FSM state encoding: IDLE=2'd0, OWN0=2'd1, OWN1=2'd2.
  - DMEM_DEPTH=1024 and burst-counter width constant.
- Sub-module rr_pick2: combinational two-way round-robin selector taking req[1:0] and last, returning a one-hot grant. The FSM, counter and response registers stay in dmem_arbiter.

Test Plan:
- Reset, then m0 write addr 28 data 0x20; m1 read addr 28 in the next cycle.
  - Required: m0_gnt in cycle 1; m1_gnt in cycle 2; m1_rvalid=1, m1_rdata=0x00000020 in cycle 3.
- Both requesters read every cycle for 6 cycles, lock=0.
  - Required: grants alternate m0,m1,m0,m1,m0,m1; each rvalid arrives one cycle after its gnt.
- m0 locked reads addrs 0..7 while m1 requests continuously, MAX_BURST=4.
  - Required: m0 granted 4 consecutive cycles, then m1 granted, then m0 resumes.
- m1 write addr 1024 data 0xDEADBEEF.
  - Required: m1_gnt=1, mem_WE=0; next cycle m1_rvalid=1, m1_err=1, m1_rdata=0.
- Assert rst=0 asynchronously mid-cycle with a read response pending.
  - Required: all gnt/rvalid/err drop immediately; after release, the first tie goes to m0.
- m0 write addr 40 data 0x2 then read addr 40, no contention.
  - Required: m0_rdata=0x00000002 with m0_rvalid exactly one cycle after the read grant.
